// File: rtl/crypto_seq_ctrl_if.sv
// Signal bundle between crypto_seq_ctrl and its instruction source, crypto core and write-back port.
// The slave modport is the controller's view; master is the view of the logic around it.
interface crypto_seq_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        core_start;
    logic [4:0]  core_round;
    logic [2:0]  core_funct3;
    logic [1:0]  core_set_type;
    logic        core_done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_ready;
    logic        busy;
    logic        illegal;

    modport master (
        output instr_valid, instruction, core_done, wb_ready,
        input  instr_ready, core_start, core_round, core_funct3, core_set_type,
               wb_valid, wb_rd, busy, illegal
    );

    modport slave (
        input  instr_valid, instruction, core_done, wb_ready,
        output instr_ready, core_start, core_round, core_funct3, core_set_type,
               wb_valid, wb_rd, busy, illegal
    );
endinterface

// File: rtl/crypto_seq_ctrl.sv
// Sequences a multi-round crypto instruction: one core_start per round, then a write-back
// handshake. Non-crypto opcodes are consumed and flagged with a one-cycle illegal pulse.
module crypto_seq_ctrl #(
    parameter logic [6:0] OPC_CRYPTO = 7'b0001011
) (
    input  logic             clk,
    input  logic             reset,
    crypto_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [4:0] r_index;
    logic [4:0] r_n;
    logic [4:0] r_rd;
    logic [2:0] r_funct3;
    logic [1:0] r_set_type;
    logic       r_illegal;

    logic       w_accept;
    logic       w_is_crypto;
    logic       w_last;
    logic       w_instr_ready;
    logic       w_core_start;
    logic       w_wb_valid;
    logic       w_busy;
    logic       w_unused;

    assign w_accept    = bus.instr_valid && (r_state == S_IDLE);
    assign w_is_crypto = (bus.instruction[6:0] == OPC_CRYPTO);
    // Only meaningful in WAIT, where r_n is at least 1.
    assign w_last      = (r_index == (r_n - 5'd1));
    assign w_unused    = ^{bus.instruction[29:25], bus.instruction[19:15]};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values, independent of statement order.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        w_next        = r_state;
        w_instr_ready = 1'b0;
        w_core_start  = 1'b0;
        w_wb_valid    = 1'b0;
        w_busy        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_instr_ready = 1'b1;
                w_busy        = 1'b0;
                if (w_accept && w_is_crypto) begin
                    w_next = (bus.instruction[24:20] == 5'd0) ? S_WB : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_core_start = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    w_next = w_last ? S_WB : S_ISSUE;
                end
            end
            S_WB: begin
                w_wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latched instruction fields and round index; illegal opcodes leave the fields untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index    <= 5'd0;
            r_n        <= 5'd0;
            r_rd       <= 5'd0;
            r_funct3   <= 3'd0;
            r_set_type <= 2'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_is_crypto;
            if (w_accept && w_is_crypto) begin
                r_index    <= 5'd0;
                r_n        <= bus.instruction[24:20];
                r_rd       <= bus.instruction[11:7];
                r_funct3   <= bus.instruction[14:12];
                r_set_type <= bus.instruction[31:30];
            end else if ((r_state == S_WAIT) && bus.core_done && !w_last) begin
                r_index <= r_index + 5'd1;
            end
        end
    end

    assign bus.instr_ready   = w_instr_ready;
    assign bus.core_start    = w_core_start;
    assign bus.core_round    = r_index;
    assign bus.core_funct3   = r_funct3;
    assign bus.core_set_type = r_set_type;
    assign bus.wb_valid      = w_wb_valid;
    assign bus.wb_rd         = r_rd;
    assign bus.busy          = w_busy;
    assign bus.illegal       = r_illegal;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Self-checking bench for crypto_seq_ctrl: expected core_start/wb events are queued when an
// instruction is driven and popped as the controller produces them.
module tb_crypto_seq_ctrl;

    localparam logic [6:0] OPC     = 7'b0001011;
    localparam logic [6:0] OPC_ALU = 7'b0110011;

    typedef struct {
        bit         is_wb;
        logic [4:0] val;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    crypto_seq_ctrl_if bus ();

    crypto_seq_ctrl #(.OPC_CRYPTO(OPC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [4:0] rd,
                                             input logic [2:0] f3, input logic [4:0] n,
                                             input logic [1:0] st);
        return {st, 5'd0, n, 5'd0, f3, rd, opc};
    endfunction

    task automatic test_reset();
        reset           = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instruction = mk_instr(OPC, 5'd7, 3'd3, 5'd2, 2'd1);
        bus.core_done   = 1'b1;
        bus.wb_ready    = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.core_start !== 1'b0 ||
            bus.wb_valid !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy=%b busy=%b start=%b wbv=%b ill=%b, want 1 0 0 0 0",
                     bus.instr_ready, bus.busy, bus.core_start, bus.wb_valid, bus.illegal);
        end
        n_checks++;
        if (bus.core_round !== 5'd0 || bus.core_funct3 !== 3'd0 || bus.core_set_type !== 2'd0 ||
            bus.wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_fields: round=%0d f3=%0d st=%0d rd=%0d, want all 0",
                     bus.core_round, bus.core_funct3, bus.core_set_type, bus.wb_rd);
        end
        bus.instr_valid = 1'b0;
        bus.core_done   = 1'b0;
        bus.wb_ready    = 1'b0;
        reset           = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b rdy=%b, want 0 1", bus.busy, bus.instr_ready);
        end
    endtask

    // Expects latched fields to still be zero, so it runs right after reset.
    task automatic test_illegal();
        bus.instruction = mk_instr(OPC_ALU, 5'd9, 3'd2, 5'd3, 2'd1);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n_checks++;
        if (bus.illegal !== 1'b1 || bus.busy !== 1'b0 || bus.core_start !== 1'b0 ||
            bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_c1: ill=%b busy=%b start=%b rdy=%b, want 1 0 0 1",
                     bus.illegal, bus.busy, bus.core_start, bus.instr_ready);
        end
        n_checks++;
        if (bus.wb_rd !== 5'd0 || bus.core_funct3 !== 3'd0 || bus.core_set_type !== 2'd0) begin
            n_fail++;
            $display("FAIL illegal_fields: rd=%0d f3=%0d st=%0d, want 0 0 0",
                     bus.wb_rd, bus.core_funct3, bus.core_set_type);
        end
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.illegal !== 1'b0 || bus.busy !== 1'b0 || bus.core_start !== 1'b0 ||
                bus.wb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_after c%0d: ill=%b busy=%b start=%b wbv=%b, want 0 0 0 0",
                         c, bus.illegal, bus.busy, bus.core_start, bus.wb_valid);
            end
        end
    endtask

    // One crypto instruction from accept to write-back. Called on a falling edge with the DUT idle.
    // With hold_valid, instr_valid stays high carrying an ALU opcode; its acceptance shows up
    // as an illegal pulse, which must come only after the write-back handshake.
    task automatic run_crypto(input string name, input logic [4:0] n, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [1:0] st, input bit done_held,
                              input int wb_stall, input bit hold_valid);
        int   cyc        = 0;
        int   wb_cyc     = -1;
        bit   prev_start = 1'b0;
        bit   hs         = 1'b0;
        exp_t e;

        n_checks++;
        if (bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_c0: got %b want 1", name, bus.instr_ready);
        end
        for (int r = 0; r < int'(n); r++) sb.push_back('{1'b0, 5'(r), 2 * r + 1});
        sb.push_back('{1'b1, rd, (n == 5'd0) ? 1 : 2 * int'(n) + 1});

        bus.instruction = mk_instr(OPC, rd, f3, n, st);
        bus.instr_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: no write-back within 200 cycles", name);
                break;
            end
            n_checks++;
            if (bus.illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL %s illegal c%0d: got %b want 0", name, cyc, bus.illegal);
            end
            if (bus.core_start === 1'b1) begin
                n_checks++;
                if (sb.size() == 0 || sb[0].is_wb) begin
                    n_fail++;
                    $display("FAIL %s extra_start c%0d: round %0d, no start expected",
                             name, cyc, bus.core_round);
                end else begin
                    e = sb.pop_front();
                    if (bus.core_round !== e.val || cyc != e.cyc || bus.core_funct3 !== f3 ||
                        bus.core_set_type !== st) begin
                        n_fail++;
                        $display("FAIL %s start: round=%0d c%0d f3=%0d st=%0d, want round=%0d c%0d f3=%0d st=%0d",
                                 name, bus.core_round, cyc, bus.core_funct3, bus.core_set_type,
                                 e.val, e.cyc, f3, st);
                    end
                end
            end
            if (hs) begin
                n_checks++;
                if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s post_wb: rdy=%b busy=%b wbv=%b, want 1 0 0",
                             name, bus.instr_ready, bus.busy, bus.wb_valid);
                end
                break;
            end
            if (bus.wb_valid === 1'b1) begin
                n_checks++;
                if (wb_cyc < 0) begin
                    if (sb.size() == 0 || !sb[0].is_wb) begin
                        n_fail++;
                        $display("FAIL %s early_wb c%0d: %0d starts still pending",
                                 name, cyc, sb.size());
                    end else begin
                        e = sb.pop_front();
                        if (cyc != e.cyc || bus.wb_rd !== e.val) begin
                            n_fail++;
                            $display("FAIL %s wb: c%0d rd=%0d, want c%0d rd=%0d",
                                     name, cyc, bus.wb_rd, e.cyc, e.val);
                        end
                    end
                    wb_cyc = cyc;
                end else if (bus.wb_rd !== rd || bus.instr_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s wb_stall c%0d: rd=%0d rdy=%b, want rd=%0d rdy=0",
                             name, cyc, bus.wb_rd, bus.instr_ready, rd);
                end
            end
            if (cyc == 1) begin
                if (hold_valid) bus.instruction = mk_instr(OPC_ALU, 5'd31, 3'd7, 5'd1, 2'd3);
                else bus.instr_valid = 1'b0;
            end
            bus.core_done = done_held ? 1'b1 : prev_start;
            prev_start    = bus.core_start;
            bus.wb_ready  = (wb_cyc >= 0) && (cyc - wb_cyc >= wb_stall);
            hs            = bus.wb_ready;
        end
        bus.wb_ready  = 1'b0;
        bus.core_done = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover: %0d expected events never seen", name, sb.size());
            sb.delete();
        end
        if (hold_valid) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            n_checks++;
            if (bus.illegal !== 1'b1 || bus.busy !== 1'b0 || bus.wb_rd !== rd ||
                bus.core_funct3 !== f3) begin
                n_fail++;
                $display("FAIL %s held_accept: ill=%b busy=%b rd=%0d f3=%0d, want 1 0 %0d %0d",
                         name, bus.illegal, bus.busy, bus.wb_rd, bus.core_funct3, rd, f3);
            end
            @(negedge clk);
            n_checks++;
            if (bus.illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL %s held_ill_pulse: got %b want 0", name, bus.illegal);
            end
        end
    endtask

    task automatic test_basic();
        run_crypto("basic_n3", 5'd3, 5'd5, 3'd4, 2'd2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_zero_rounds();
        run_crypto("zero_n0", 5'd0, 5'd12, 3'd1, 2'd1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_wb_backpressure();
        run_crypto("stall_n2", 5'd2, 5'd17, 3'd6, 2'd3, 1'b0, 4, 1'b1);
    endtask

    task automatic test_done_held();
        run_crypto("done_held_n2", 5'd2, 5'd3, 3'd5, 2'd0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_crypto("b2b_n1", 5'd1, 5'd1, 3'd2, 2'd1, 1'b0, 0, 1'b0);
        run_crypto("b2b_n31", 5'd31, 5'd30, 3'd7, 2'd3, 1'b0, 1, 1'b0);
    endtask

    // N=4, reset lands in WAIT of round 1 together with core_done.
    task automatic test_reset_mid();
        bit   prev_start = 1'b0;
        exp_t e;
        sb.push_back('{1'b0, 5'd0, 1});
        sb.push_back('{1'b0, 5'd1, 3});
        bus.instruction = mk_instr(OPC, 5'd21, 3'd3, 5'd4, 2'd2);
        bus.instr_valid = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (bus.core_start === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rst_mid extra_start c%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.core_round !== e.val || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL rst_mid start: round=%0d c%0d, want round=%0d c%0d",
                                 bus.core_round, cyc, e.val, e.cyc);
                    end
                end
            end
            bus.instr_valid = 1'b0;
            bus.core_done   = prev_start;
            prev_start      = bus.core_start;
        end
        reset         = 1'b1;
        bus.core_done = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        bus.core_done = 1'b0;
        n_checks++;
        if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.core_round !== 5'd0 ||
            bus.wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid idle: rdy=%b busy=%b round=%0d rd=%0d, want 1 0 0 0",
                     bus.instr_ready, bus.busy, bus.core_round, bus.wb_rd);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.core_start !== 1'b0 || bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid quiet +%0d: start=%b wbv=%b busy=%b, want 0 0 0",
                         c, bus.core_start, bus.wb_valid, bus.busy);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid leftover: %0d starts never seen", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instruction = 32'd0;
        bus.core_done   = 1'b0;
        bus.wb_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_illegal();
        test_basic();
        test_zero_rounds();
        test_wb_backpressure();
        test_done_held();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
